// File: rtl/issue_queue_wakeup.sv
// Compacting issue queue with writeback-snoop operand wakeup and oldest-ready select.
// Optional IQ_WB_BYPASS_EN: same-cycle wakeup-to-issue by forwarding wb_data onto iss_op.
module issue_queue_wakeup #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int QUEUE_SIZE   = 4,
    parameter int NUM_WB       = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [INST_ID_BITS-1:0]          in_inst_id,
    input  logic [31:0]                      in_inst,
    input  logic [63:0]                      in_pc,
    input  logic [MAX_OPERANDS*PRN_BITS-1:0] in_src_prn,
    input  logic [MAX_OPERANDS-1:0]          in_src_rdy,
    input  logic [MAX_OPERANDS*64-1:0]       in_src_data,
    input  logic [MAX_OPERANDS*PRN_BITS-1:0] in_dst_prn,
    input  logic [NUM_WB-1:0]                wb_valid,
    input  logic [NUM_WB*PRN_BITS-1:0]       wb_prn,
    input  logic [NUM_WB*64-1:0]             wb_data,
    output logic                             iss_valid,
    input  logic                             iss_ready,
    output logic [INST_ID_BITS-1:0]          iss_inst_id,
    output logic [31:0]                      iss_inst,
    output logic [63:0]                      iss_pc,
    output logic [MAX_OPERANDS*64-1:0]       iss_op,
    output logic [MAX_OPERANDS*PRN_BITS-1:0] iss_dst_prn,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]  count
);
    localparam int CW = $clog2(QUEUE_SIZE + 1);
    localparam int IW = $clog2(QUEUE_SIZE);

    logic [CW-1:0]                      count_reg;
    logic [INST_ID_BITS-1:0]            id_reg   [QUEUE_SIZE];
    logic [31:0]                        inst_reg [QUEUE_SIZE];
    logic [63:0]                        pc_reg   [QUEUE_SIZE];
    logic [MAX_OPERANDS*PRN_BITS-1:0]   dst_reg  [QUEUE_SIZE];
    logic [PRN_BITS-1:0]                prn_reg  [QUEUE_SIZE][MAX_OPERANDS];
    logic [MAX_OPERANDS-1:0]            rdy_reg  [QUEUE_SIZE];
    logic [63:0]                        data_reg [QUEUE_SIZE][MAX_OPERANDS];

    logic [INST_ID_BITS-1:0]            id_next   [QUEUE_SIZE];
    logic [31:0]                        inst_next [QUEUE_SIZE];
    logic [63:0]                        pc_next   [QUEUE_SIZE];
    logic [MAX_OPERANDS*PRN_BITS-1:0]   dst_next  [QUEUE_SIZE];
    logic [PRN_BITS-1:0]                prn_next  [QUEUE_SIZE][MAX_OPERANDS];
    logic [MAX_OPERANDS-1:0]            rdy_next  [QUEUE_SIZE];
    logic [63:0]                        data_next [QUEUE_SIZE][MAX_OPERANDS];

    // Stored operands after this cycle's wakeup has been applied
    logic [MAX_OPERANDS-1:0]            wk_rdy  [QUEUE_SIZE];
    logic [63:0]                        wk_data [QUEUE_SIZE][MAX_OPERANDS];

    logic [PRN_BITS-1:0]                in_prn_arr  [MAX_OPERANDS];
    logic [63:0]                        in_data_arr [MAX_OPERANDS];
    logic [MAX_OPERANDS-1:0]            new_rdy;
    logic [63:0]                        new_data [MAX_OPERANDS];

    logic [QUEUE_SIZE-1:0]              eligible;
    logic                               cand_found;
    logic [IW-1:0]                      cand_idx;
    logic                               dispatch_fire;
    logic                               issue_fire;
    logic [CW-1:0]                      disp_idx;

    // Returns {hit, data}; the lowest-index matching port wins
    function automatic logic [64:0] wb_lookup(
        input logic [PRN_BITS-1:0]        prn,
        input logic [NUM_WB-1:0]          v,
        input logic [NUM_WB*PRN_BITS-1:0] p,
        input logic [NUM_WB*64-1:0]       d
    );
        logic [64:0] r;
        r = '0;
        for (int w = NUM_WB - 1; w >= 0; w--) begin
            if (v[w] && (p[w*PRN_BITS +: PRN_BITS] == prn)) begin
                r = {1'b1, d[w*64 +: 64]};
            end
        end
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < MAX_OPERANDS; gi++) begin : g_in_unpack
            assign in_prn_arr[gi]  = in_src_prn[gi*PRN_BITS +: PRN_BITS];
            assign in_data_arr[gi] = in_src_data[gi*64 +: 64];
        end
    endgenerate

    always_comb begin
        logic [64:0] lk;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            for (int k = 0; k < MAX_OPERANDS; k++) begin
                lk = wb_lookup(prn_reg[i][k], wb_valid, wb_prn, wb_data);
                wk_rdy[i][k]  = rdy_reg[i][k] | lk[64];
                wk_data[i][k] = (!rdy_reg[i][k] && lk[64]) ? lk[63:0] : data_reg[i][k];
            end
        end
        for (int k = 0; k < MAX_OPERANDS; k++) begin
            lk = wb_lookup(in_prn_arr[k], wb_valid, wb_prn, wb_data);
            new_rdy[k]  = in_src_rdy[k] | lk[64];
            new_data[k] = (!in_src_rdy[k] && lk[64]) ? lk[63:0] : in_data_arr[k];
        end
    end

    generate
        for (gi = 0; gi < QUEUE_SIZE; gi++) begin : g_elig
`ifdef IQ_WB_BYPASS_EN
            assign eligible[gi] = (CW'(gi) < count_reg) && (&wk_rdy[gi]);
`else
            assign eligible[gi] = (CW'(gi) < count_reg) && (&rdy_reg[gi]);
`endif
        end
    endgenerate

    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int i = QUEUE_SIZE - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                cand_found = 1'b1;
                cand_idx   = IW'(i);
            end
        end
    end

    assign in_ready      = (count_reg < CW'(QUEUE_SIZE)) && !flush;
    assign iss_valid     = cand_found && !flush;
    assign dispatch_fire = in_valid && in_ready;
    assign issue_fire    = iss_valid && iss_ready;
    assign disp_idx      = count_reg - CW'(issue_fire);
    assign count         = count_reg;

    always_comb begin
        iss_inst_id = '0;
        iss_inst    = '0;
        iss_pc      = '0;
        iss_op      = '0;
        iss_dst_prn = '0;
        if (iss_valid) begin
            iss_inst_id = id_reg[cand_idx];
            iss_inst    = inst_reg[cand_idx];
            iss_pc      = pc_reg[cand_idx];
            iss_dst_prn = dst_reg[cand_idx];
            for (int k = 0; k < MAX_OPERANDS; k++) begin
`ifdef IQ_WB_BYPASS_EN
                iss_op[k*64 +: 64] = wk_data[cand_idx][k];
`else
                iss_op[k*64 +: 64] = data_reg[cand_idx][k];
`endif
            end
        end
    end

    // Entries at or above the issued slot pull from the slot above; dispatch lands on the new tail
    always_comb begin
        logic [IW-1:0] src;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            src = IW'(i);
            if (issue_fire && (IW'(i) >= cand_idx) && (i < QUEUE_SIZE - 1)) begin
                src = IW'(i + 1);
            end
            id_next[i]   = id_reg[src];
            inst_next[i] = inst_reg[src];
            pc_next[i]   = pc_reg[src];
            dst_next[i]  = dst_reg[src];
            rdy_next[i]  = wk_rdy[src];
            for (int k = 0; k < MAX_OPERANDS; k++) begin
                prn_next[i][k]  = prn_reg[src][k];
                data_next[i][k] = wk_data[src][k];
            end
            if (dispatch_fire && (CW'(i) == disp_idx)) begin
                id_next[i]   = in_inst_id;
                inst_next[i] = in_inst;
                pc_next[i]   = in_pc;
                dst_next[i]  = in_dst_prn;
                rdy_next[i]  = new_rdy;
                for (int k = 0; k < MAX_OPERANDS; k++) begin
                    prn_next[i][k]  = in_prn_arr[k];
                    data_next[i][k] = new_data[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(dispatch_fire) - CW'(issue_fire);
        end
    end

    // Entry payload needs no reset: slots at or above count are never observed
    always_ff @(posedge clk) begin
        id_reg   <= id_next;
        inst_reg <= inst_next;
        pc_reg   <= pc_next;
        dst_reg  <= dst_next;
        prn_reg  <= prn_next;
        rdy_reg  <= rdy_next;
        data_reg <= data_next;
    end
endmodule

// File: doc/issue_queue_wakeup.md
Name: issue_queue_wakeup

Overview:
- Parametrised successor to the single-slot issue-queue handshake.
- Buffers up to QUEUE_SIZE dispatched instructions and captures missing source operands by snooping NUM_WB writeback broadcast ports.
- Issues the oldest fully-ready entry to one functional unit over a valid/ready handshake.
- Sits between rename/dispatch and an FU; supports pipeline flush.

Parameters:
- INST_ID_BITS, 6, instruction ID width
- PRN_BITS, 6, physical register number width
- MAX_OPERANDS, 3, source operands per instruction; also the number of destination PRN slots
- QUEUE_SIZE, 4, entry count (>=2)
- NUM_WB, 2, writeback broadcast ports snooped for wakeup

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all entries
- in_valid  in  1  dispatch request
- in_ready  out  1  queue can accept this cycle
- in_inst_id  in  INST_ID_BITS  instruction ID
- in_inst  in  32  instruction word
- in_pc  in  64  program counter
- in_src_prn  in  MAX_OPERANDS*PRN_BITS  source PRNs; slot k at [k*PRN_BITS +: PRN_BITS]
- in_src_rdy  in  MAX_OPERANDS  per-operand value already valid
- in_src_data  in  MAX_OPERANDS*64  operand values; used where rdy=1
- in_dst_prn  in  MAX_OPERANDS*PRN_BITS  destination PRNs, carried unchanged
- wb_valid  in  NUM_WB  broadcast valid
- wb_prn  in  NUM_WB*PRN_BITS  broadcast PRN
- wb_data  in  NUM_WB*64  broadcast value
- iss_valid  out  1  issue candidate present
- iss_ready  in  1  FU accepts
- iss_inst_id  out  INST_ID_BITS  issued ID
- iss_inst  out  32  issued instruction
- iss_pc  out  64  issued PC
- iss_op  out  MAX_OPERANDS*64  issued operand values
- iss_dst_prn  out  MAX_OPERANDS*PRN_BITS  issued destination PRNs
- count  out  $clog2(QUEUE_SIZE+1)  occupied entries

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Storage is a compacting array. Entry 0 is the oldest; valid entries are always contiguous 0..count-1.
- Each entry holds: ID, inst, pc, dst PRNs, and per operand a prn, rdy bit and 64-bit data.
- Reset (rst=1 at clk edge): count=0, all entry valid bits 0. All outputs then read 0, except in_ready=1. Reset mid-operation drops every entry.
- in_ready = (count < QUEUE_SIZE) && !flush. It is computed from the registered count and ignores a same-cycle issue, so no dispatch is accepted when full, even if an issue occurs that cycle.
- Dispatch fires when in_valid && in_ready. The new entry is written at index count, or count-1 if an issue also fires that cycle.
- Dispatch-cycle wakeup: for any operand with in_src_rdy=0 whose prn matches a valid wb port this cycle, the entry stores rdy=1 and that wb_data.
- Wakeup: every cycle, each stored operand with rdy=0 is compared against all wb ports. On a match, rdy<=1 and data<=wb_data.
- Multiple wb ports matching the same PRN: the lowest-index port wins.
- Select: the lowest-index valid entry whose operands are all rdy (registered state) is the candidate. iss_valid=1 when a candidate exists and flush=0.
- Issue outputs are combinational from the candidate and read all zeros when iss_valid=0.
- Issue fires when iss_valid && iss_ready. At the clock edge the candidate is removed and entries above it shift down one index, keeping age order.
- Without IQ_WB_BYPASS_EN, wakeup-to-issue latency is one cycle.
- count update: count <= count + dispatch_fire - issue_fire.
- iss_valid with iss_ready=0: the candidate holds and its outputs stay stable unless an older entry becomes ready. Younger entries continue to wake up.
- flush=1: in_ready=0 and iss_valid=0 combinationally. At the edge count<=0 and all entries are invalidated. Flush takes priority over dispatch, issue and wakeup in the same cycle.
- Empty queue: iss_valid=0. A dispatch with all operands rdy is issuable the next cycle (minimum latency 1).

Optional Feature:
- Macro: IQ_WB_BYPASS_EN.
- Defined: an entry whose only missing operands are matched by wb ports this cycle is also eligible for select. The matching wb_data is forwarded combinationally onto iss_op, giving zero-cycle wakeup-to-issue.
- A dispatching instruction is never bypass-issued in its dispatch cycle.
- Undefined: select uses registered rdy bits only, with one-cycle latency as above.

Test Plan:
- Reset, then dispatch ID=5 with all rdy=1 and op={1,2,3} -> next cycle iss_valid=1, iss_inst_id=5, iss_op={1,2,3}; with iss_ready=1, count returns to 0.
- Dispatch ID=1 (src0 prn=9, rdy=0), then ID=2 (all rdy); hold iss_ready=1 -> ID=2 issues first. Then wb_valid[0]=1, prn=9, data=0xAA -> ID=1 issues one cycle later (same cycle with IQ_WB_BYPASS_EN) with op0=0xAA.
- Fill 4 entries with rdy=0 -> in_ready=0 and count=4. A further in_valid=1 is not accepted. Wake entry 2 -> entry 2 issues, entries 3→2 shift, count=3.
- Dispatch operand prn=7 rdy=0 while wb port1 broadcasts prn=7 data=0x55 in the same cycle -> entry stored ready with 0x55.
- wb port0 and port1 both broadcast prn=4 with data 0x10 and 0x20 -> captured data=0x10.
- With 3 entries and iss_ready=1, assert flush together with in_valid=1 -> iss_valid=0, in_ready=0; next cycle count=0. Also assert rst mid-wakeup -> count=0 and iss_valid=0.
